// File: rtl/sseg_scan_decoder.sv
// Receiver for a multiplexed active-low 7-segment bus: filters scan transitions,
// decodes each stable segment pattern back to BCD and tracks frame completion.
module sseg_scan_decoder #(
   parameter int unsigned N_DIG      = 4,
   parameter int unsigned STABLE_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [0:6]           SSeg,
   input  logic [N_DIG-1:0]     an,
   output logic [4*N_DIG-1:0]   digits,
   output logic [N_DIG-1:0]     digit_vld,
   output logic                 frame_done,
   output logic                 err
);

   localparam int unsigned SW = N_DIG + 7;
   localparam int unsigned CW = 4;
   localparam int unsigned DW = 4 * N_DIG;

   logic [SW-1:0]    s_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_DIG-1:0] seen_q, seen_d;
   logic [DW-1:0]    digits_q, digits_d;
   logic [N_DIG-1:0] vld_q, vld_d;
   logic             fd_q, fd_d;
   logic             err_q, err_d;

   logic [SW-1:0]    smp;
   logic             same;
   logic             cap;
   logic [N_DIG-1:0] sel;
   logic             sel_none;
   logic             sel_multi;
   logic [3:0]       dec_val;
   logic             dec_ok;
   logic             dec_blank;

   // Stability filter: a capture fires once, when the counter reaches STABLE_CYC
   always_comb begin
      smp  = {an, SSeg};
      same = (smp == s_q);
      cnt_d = '0;
      if (same) begin
         if (cnt_q != CW'(STABLE_CYC)) cnt_d = cnt_q + CW'(1);
         else                          cnt_d = cnt_q;
      end
      cap = same && (cnt_q == CW'(STABLE_CYC - 1));
   end

   // Anode classification from the sampled bus (active-low -> one-hot select)
   always_comb begin
      sel       = ~s_q[SW-1:7];
      sel_none  = (sel == '0);
      sel_multi = ((sel & (sel - N_DIG'(1))) != '0);
   end

   // Segment pattern decode, string order a..g, active-low
   always_comb begin
      dec_val   = 4'hF;
      dec_ok    = 1'b0;
      dec_blank = 1'b0;
      case (s_q[6:0])
         7'b0000001: begin dec_val = 4'd0; dec_ok = 1'b1; end
         7'b1001111: begin dec_val = 4'd1; dec_ok = 1'b1; end
         7'b0010010: begin dec_val = 4'd2; dec_ok = 1'b1; end
         7'b0000110: begin dec_val = 4'd3; dec_ok = 1'b1; end
         7'b1001100: begin dec_val = 4'd4; dec_ok = 1'b1; end
         7'b0100100: begin dec_val = 4'd5; dec_ok = 1'b1; end
         7'b0100000: begin dec_val = 4'd6; dec_ok = 1'b1; end
         7'b0001111: begin dec_val = 4'd7; dec_ok = 1'b1; end
         7'b0000000: begin dec_val = 4'd8; dec_ok = 1'b1; end
         7'b0000100: begin dec_val = 4'd9; dec_ok = 1'b1; end
         7'b1111111: dec_blank = 1'b1;
         default: ;
      endcase
   end

   // Capture update: nibble store, frame tracking and error flag
   always_comb begin
      digits_d = digits_q;
      vld_d    = vld_q;
      seen_d   = seen_q;
      fd_d     = 1'b0;
      err_d    = 1'b0;
      if (cap && !sel_none) begin
         if (sel_multi || !(dec_ok || dec_blank)) begin
            err_d = 1'b1;
         end else begin
            for (int k = 0; k < int'(N_DIG); k++) begin
               if (sel[k]) begin
                  digits_d[4*k +: 4] = dec_val;
                  vld_d[k]           = dec_ok;
               end
            end
            seen_d = seen_q | sel;
            if (&seen_d) begin
               fd_d   = 1'b1;
               seen_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_q      <= '1;
         cnt_q    <= '0;
         seen_q   <= '0;
         digits_q <= '0;
         vld_q    <= '0;
         fd_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         s_q      <= smp;
         cnt_q    <= cnt_d;
         seen_q   <= seen_d;
         digits_q <= digits_d;
         vld_q    <= vld_d;
         fd_q     <= fd_d;
         err_q    <= err_d;
      end
   end

   assign digits     = digits_q;
   assign digit_vld  = vld_q;
   assign frame_done = fd_q;
   assign err        = err_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: run-length behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sseg_scan_decoder;

   localparam int N  = 4;
   localparam int SC = 4;

   logic          clk;
   logic          rst;
   logic [0:6]    SSeg;
   logic [N-1:0]  an;
   logic [4*N-1:0] digits;
   logic [N-1:0]  digit_vld;
   logic          frame_done;
   logic          err;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;
   int err_cnt = 0;

   sseg_scan_decoder #(.N_DIG(N), .STABLE_CYC(SC)) dut (
      .clk(clk), .rst(rst), .SSeg(SSeg), .an(an),
      .digits(digits), .digit_vld(digit_vld),
      .frame_done(frame_done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Segment strings a..g for 0..9
   logic [6:0] pat [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   localparam logic [6:0] BLANK = 7'b1111111;

   // Model state: a capture happens when the same bus value has been seen on
   // exactly SC+1 consecutive edges (the reset value counts as the first).
   logic [N+6:0] m_last;
   int           m_run;
   int           m_dig [N];
   logic [N-1:0] m_vld;
   logic [N-1:0] m_seen;
   logic         m_fd;
   logic         m_err;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_last = '1;
         m_run  = 1;
         for (int k = 0; k < N; k++) m_dig[k] = 0;
         m_vld  = '0;
         m_seen = '0;
         m_fd   = 1'b0;
         m_err  = 1'b0;
      end else begin
         logic [N+6:0] cur;
         int nlow, pos, val;
         cur   = {an, SSeg};
         m_fd  = 1'b0;
         m_err = 1'b0;
         if (cur == m_last) m_run = m_run + 1;
         else begin m_run = 1; m_last = cur; end
         if (m_run == SC + 1) begin
            nlow = 0; pos = 0;
            for (int k = 0; k < N; k++) if (an[k] == 1'b0) begin nlow++; pos = k; end
            if (nlow > 1) m_err = 1'b1;
            else if (nlow == 1) begin
               val = -1;
               for (int v = 0; v < 10; v++) if (pat[v] == cur[6:0]) val = v;
               if (val < 0 && cur[6:0] != BLANK) m_err = 1'b1;
               else begin
                  m_dig[pos] = (val < 0) ? 15 : val;
                  m_vld[pos] = (val >= 0);
                  m_seen[pos] = 1'b1;
                  if (m_seen == {N{1'b1}}) begin m_fd = 1'b1; m_seen = '0; end
               end
            end
         end
      end
   end

   // Per-cycle compare against the model, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         logic [4*N-1:0] ed;
         for (int k = 0; k < N; k++) ed[4*k +: 4] = 4'(m_dig[k]);
         checks++;
         if (digits !== ed || digit_vld !== m_vld || frame_done !== m_fd || err !== m_err) begin
            errors++;
            $display("FAIL model_cmp t=%0t digits=%h/%h vld=%b/%b fd=%b/%b err=%b/%b (got/exp)",
                     $time, digits, ed, digit_vld, m_vld, frame_done, m_fd, err, m_err);
         end
         if (frame_done === 1'b1) fd_cnt++;
         if (err === 1'b1) err_cnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Entered at a rising edge; drives at +3 and returns after n further edges
   task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
      #3;
      an   = a;
      SSeg = s;
      repeat (n) @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst  = 1'b0;
      an   = '1;
      SSeg = '1;
      #12;
      chk("reset_digits", 32'(digits), 32'h0);
      chk("reset_vld", 32'(digit_vld), 32'h0);
      chk("reset_fd", 32'(frame_done), 32'h0);
      chk("reset_err", 32'(err), 32'h0);
      rst = 1'b1;
      @(posedge clk);
      hold(4'b1111, BLANK, 8);

      // Single "5" on position 0: capture on the 5th edge after the change
      hold(4'b1110, pat[5], 4);
      #1 chk("t1_before_cap", 32'(digits), 32'h0);
      @(posedge clk);
      #1 chk("t1_digit", 32'(digits), 32'h0005);
      chk("t1_vld", 32'(digit_vld), 32'b0001);
      repeat (5) @(posedge clk);

      // Short glitch never captures
      hold(4'b1101, pat[3], 3);
      hold(4'b1111, BLANK, 8);
      chk("t2_digits", 32'(digits), 32'h0005);
      chk("t2_vld", 32'(digit_vld), 32'b0001);
      chk("t2_err_cnt", 32'(err_cnt), 32'd0);

      // Full scan 5, blank, blank, 0
      hold(4'b1110, pat[5], 8);
      hold(4'b1101, BLANK, 8);
      hold(4'b1011, BLANK, 8);
      chk("t3_fd_before", 32'(fd_cnt), 32'd0);
      hold(4'b0111, pat[0], 8);
      hold(4'b1111, BLANK, 8);
      chk("t3_digits", 32'(digits), 32'h0FF5);
      chk("t3_vld", 32'(digit_vld), 32'b1001);
      chk("t3_fd_cnt", 32'(fd_cnt), 32'd1);

      // Illegal segment pattern
      hold(4'b1110, 7'b1111110, 8);
      hold(4'b1111, BLANK, 8);
      chk("t4_err_cnt", 32'(err_cnt), 32'd1);
      chk("t4_digits", 32'(digits), 32'h0FF5);

      // Multi-hot anode with a valid "8"
      hold(4'b1100, pat[8], 8);
      hold(4'b1111, BLANK, 8);
      chk("t5_err_cnt", 32'(err_cnt), 32'd2);
      chk("t5_digits", 32'(digits), 32'h0FF5);
      chk("t5_vld", 32'(digit_vld), 32'b1001);
      chk("t5_fd_cnt", 32'(fd_cnt), 32'd1);

      // Three captures, then asynchronous reset mid-scan
      hold(4'b1110, pat[1], 8);
      hold(4'b1101, pat[2], 8);
      hold(4'b1011, pat[3], 8);
      hold(4'b1111, BLANK, 2);
      chk("t6_pre_digits", 32'(digits), 32'h0321);
      #1 rst = 1'b0;
      #1;
      chk("t6_rst_digits", 32'(digits), 32'h0);
      chk("t6_rst_vld", 32'(digit_vld), 32'h0);
      chk("t6_rst_fd", 32'(frame_done), 32'h0);
      chk("t6_rst_err", 32'(err), 32'h0);
      rst = 1'b1;
      @(posedge clk);
      hold(4'b1110, pat[7], 8);
      hold(4'b1101, pat[9], 8);
      hold(4'b1011, pat[4], 8);
      chk("t6_fd_after3", 32'(fd_cnt), 32'd1);
      hold(4'b0111, pat[6], 8);
      hold(4'b1111, BLANK, 8);
      chk("t6_fd_after4", 32'(fd_cnt), 32'd2);
      chk("t6_digits", 32'(digits), 32'h6497);
      chk("t6_vld", 32'(digit_vld), 32'b1111);
      chk("t6_err_cnt", 32'(err_cnt), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Display-side receiver for the multiplexed 7-segment bus driven by the BCD/display path: it is the decoder for the BCD-to-segment encoder.
- Samples the anode and segment lines, filters scan transitions, and decodes each stable segment pattern back to a BCD nibble.
- Stores one nibble per digit position and flags completed frames and illegal bus states.
- Used as a self-check monitor in top-level benches and as the readback path for on-board loopback tests.

Parameters:
- N_DIG, 4, number of anode lines and digit positions.
- STABLE_CYC, 4, consecutive identical samples required before a capture (range 2..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- SSeg  input  [0:6]  segment lines, active-low; SSeg[0]=a … SSeg[6]=g.
- an  input  N_DIG  anode enables, active-low, at most one low.
- digits  output  4*N_DIG  decoded nibble per position; digits[4k+3:4k] is position k.
- digit_vld  output  N_DIG  position k holds a decimal value (0-9).
- frame_done  output  1  one-cycle pulse when every position has been captured since the last pulse.
- err  output  1  one-cycle pulse on an illegal pattern or a multi-hot anode.

Behaviour:
- Reset (rst low, asynchronous) clears all state:
  - digits=0, digit_vld=0, frame_done=0, err=0.
  - Sample register s_q = all-ones (idle), stability counter cnt=0, seen mask=0.
- Every edge:
  - s_q <= {an,SSeg}.
  - If {an,SSeg} != s_q, then cnt <= 0.
  - Otherwise cnt increments, saturating at STABLE_CYC.
- Capture fires on the edge where cnt goes STABLE_CYC-1 -> STABLE_CYC. It fires exactly once per stable window.
  - Latency: outputs update STABLE_CYC+1 edges after the input changes (5 clocks at default).
  - A change shorter than that never captures.
- At capture, the anode pattern is classified:
  - an all-high: idle; nothing happens.
  - Two or more lows: err pulses; nothing else changes.
  - Exactly one low at position k: the segment pattern is decoded as below.
- Segment decode (string order a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A decimal match writes the digit to nibble k and sets digit_vld[k]=1.
  - Blank (1111111) writes nibble k=4'hF and sets digit_vld[k]=0. Blank is not an error.
  - Any other pattern pulses err; nibble k and digit_vld[k] are unchanged.
- Any non-erroring capture at position k sets seen[k].
  - When this makes seen all-ones, frame_done pulses on that same edge and seen clears to 0.
  - Recapturing a position already in seen before the frame completes is allowed; it updates the nibble and does not pulse frame_done.
- At most one capture occurs per cycle, so frame_done and err can never pulse together.
- If rst asserts mid-window, state returns to the reset values immediately. After release, the STABLE_CYC window restarts from cnt=0.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset release, then an=1110, SSeg=0100100 held 10 cycles -> exactly one capture, 5 edges after the change: digits[3:0]=5, digit_vld=0001; no err.
- an=1101 with SSeg=0000110 held only 3 cycles, then back to an=1111 -> no capture; digits and digit_vld unchanged.
- Scan positions 0..3 with "5", blank, blank, "0", each held 8 cycles -> digits=16'h0FF5, digit_vld=1001, a single frame_done pulse on the capture of position 3.
- an=1110, SSeg=1111110 held 8 cycles -> one err pulse; digits[3:0] retains its prior value.
- an=1100 with a valid "8" held 8 cycles -> one err pulse; no digit or seen change.
- rst driven low for 1 ns in the middle of a scan after 3 of 4 captures -> all outputs 0 at once; the next full 4-digit scan needs all 4 captures before frame_done.
